mux4_rr_arbiter: RTL

//   Round-robin arbiter that shares one Mux4x1Nbits datapath mux between four requesters.

---
 rtl/mux4_rr_arbiter_pkg.sv | 23 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 41 ++++
 rtl/mux4_rr_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux4_rr_arbiter_pkg
// Brief   : Shared definitions for the four-way round-robin mux arbiter:
//           state encodings, requester count and index-to-one-hot helper.
// Revision: 1.0 - initial release
// ============================================================================
package mux4_rr_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Convert a 2-bit requester index into its one-hot grant vector.
  function automatic logic [NREQ-1:0] idx2onehot(input logic [1:0] idx);
    idx2onehot = 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick4
// Brief   : Combinational round-robin picker. Rotates req so that the slot
//           after 'last' sits at bit 0, priority-encodes the lowest set bit,
//           and maps the offset back to an absolute requester index.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] w_base;
  logic [3:0] w_rot;
  logic [1:0] w_off;

  assign w_base = last + 2'd1;

  // Rotated view: w_rot[i] is the requester i places after the last owner.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_rot
      assign w_rot[i] = req[w_base + 2'(i)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the closest requester after last.
  always_comb begin
    w_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rot[i]) w_off = 2'(i);
    end
  end

  assign any = |w_rot;
  assign win = w_base + w_off;

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux4_rr_arbiter
// Brief   : Round-robin arbiter sharing one 4:1 datapath mux between four
//           requesters. Registers a one-hot grant plus the matching mux
//           select and holds ownership until the owner drops its request.
//           Optional macro MUX_ARB_TIMEOUT_EN bounds ownership to MAX_HOLD
//           cycles and adds a one-cycle 'timeout' pulse on forced release.
// Revision: 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter logic [1:0] RESET_LAST = 2'd3,
  parameter int         MAX_HOLD   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  generate
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_hold_range_chk
      $error("MAX_HOLD must be within 1..255");
    end
  endgenerate

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [3:0] r_grant;
  logic [3:0] w_grant_nxt;
  logic       r_busy;
  logic       w_new_grant;
  logic       w_owner_req;
  logic       w_force;
  logic [3:0] w_search;
  logic       w_any;
  logic [1:0] w_win;

  assign w_owner_req = req[r_last];

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] c_hold_lim = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  assign w_force = (r_state == ARB_OWN) && w_owner_req && (r_hold_cnt == c_hold_lim);
`else
  assign w_force = 1'b0;
`endif

  // While owned, the current owner is excluded so a release always moves on.
  assign w_search = (r_state == ARB_OWN) ? (req & ~idx2onehot(r_last)) : req;

  rr_pick4 u_pick (
    .req  (w_search),
    .last (r_last),
    .any  (w_any),
    .win  (w_win)
  );

  // Next-state: hold, hand over without a bubble, or fall back to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_new_grant = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_OWN;
          w_last_nxt  = w_win;
          w_grant_nxt = idx2onehot(w_win);
          w_new_grant = 1'b1;
        end
      end
      ARB_OWN: begin
        if (!(w_owner_req && !w_force)) begin
          if (w_any) begin
            w_last_nxt  = w_win;
            w_grant_nxt = idx2onehot(w_win);
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = 4'b0000;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = 4'b0000;
      end
    endcase
  end

  // State, owner index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_last  <= RESET_LAST;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= (w_state_nxt == ARB_OWN);
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Ownership age counter and forced-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (w_new_grant) begin
        r_hold_cnt <= 8'd0;
      end else if (r_state == ARB_OWN) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
    end
  end

  assign timeout = r_timeout;
`endif

  // sel is the registered owner index; it only moves together with grant.
  assign grant = r_grant;
  assign sel   = r_last;
  assign busy  = r_busy;

endmodule
`default_nettype wire
